vga_sprite_compositor: RTL and testbench

Parametrised successor to the single-box VGA draw stage: composites one movable sprite over a background image for a 640x480-class VGA timing generator. It issues pixel addresses to an external background ROM and sprite ROM, aligns their registered data through a configurable-latency pipeline, and drives 4-bit RGB. Sprite position updates once per frame from direction buttons, with wrap or clamp edge handling and hold-to-accelerate.

---
 rtl/vga_sprite_compositor.sv | 179 +++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// Composites one movable sprite over a background image for a 640x480-class VGA timing source.
// Optional build macro SPRITE_TRANSPARENCY_EN: sprite pixels equal to TRANSPARENT_KEY show the background.
module vga_sprite_compositor #(
  parameter int unsigned H_PIXELS        = 640,
  parameter int unsigned V_PIXELS        = 480,
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 64,
  parameter int unsigned START_X         = 304,
  parameter int unsigned START_Y         = 208,
  parameter int unsigned ROM_LATENCY     = 1,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FAST_STEP       = 4,
  parameter int unsigned HOLD_FRAMES     = 30,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F,
  localparam int unsigned SPR_AW = $clog2((SPR_W > SPR_H) ? SPR_W : SPR_H)
) (
  input  logic              Master_Clock_In,
  input  logic              Reset_N_In,
  input  logic              Disp_Ena_In,
  input  logic [9:0]        Val_Col_In,
  input  logic [9:0]        Val_Row_In,
  input  logic              Up,
  input  logic              Down,
  input  logic              Left,
  input  logic              Right,
  input  logic              Edge_Mode_In,
  output logic [9:0]        Bg_Addr_X,
  output logic [9:0]        Bg_Addr_Y,
  input  logic [11:0]       Bg_Data_In,
  output logic [SPR_AW-1:0] Spr_Addr_X,
  output logic [SPR_AW-1:0] Spr_Addr_Y,
  input  logic [11:0]       Spr_Data_In,
  output logic [3:0]        Red,
  output logic [3:0]        Green,
  output logic [3:0]        Blue,
  output logic [9:0]        Sprite_X,
  output logic [9:0]        Sprite_Y,
  output logic              Frame_Tick
);

  localparam int unsigned CNT_W     = $clog2(HOLD_FRAMES + 1);
  localparam logic [10:0] X_MAX     = 11'(H_PIXELS - SPR_W);
  localparam logic [10:0] Y_MAX     = 11'(V_PIXELS - SPR_H);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  typedef enum logic {NORMAL, FAST} move_state_t;

  move_state_t      state;
  logic [CNT_W-1:0] hold_cnt;

  logic [10:0] col_w, row_w, sx_w, sy_w;
  logic        valid_c, hit_c, frame_end_c;
  logic [9:0]  rel_x_c, rel_y_c;

  logic [ROM_LATENCY:0] valid_pipe, hit_pipe;
  logic [11:0]          pix_c;

  logic               h_eff_c, v_eff_c;
  logic signed [10:0] step_c, dx_c, dy_c, nx_c, ny_c;
  logic [9:0]         next_x_c, next_y_c;

  // Stage A: classify the incoming coordinate against the active area and sprite box
  assign col_w   = {1'b0, Val_Col_In};
  assign row_w   = {1'b0, Val_Row_In};
  assign sx_w    = {1'b0, Sprite_X};
  assign sy_w    = {1'b0, Sprite_Y};
  assign valid_c = Disp_Ena_In && (col_w < 11'(H_PIXELS)) && (row_w < 11'(V_PIXELS));
  assign hit_c   = valid_c && (col_w >= sx_w) && (col_w < sx_w + 11'(SPR_W))
                           && (row_w >= sy_w) && (row_w < sy_w + 11'(SPR_H));
  assign rel_x_c = Val_Col_In - Sprite_X;
  assign rel_y_c = Val_Row_In - Sprite_Y;
  assign frame_end_c = Disp_Ena_In && (Val_Col_In == 10'(H_PIXELS - 1))
                                   && (Val_Row_In == 10'(V_PIXELS - 1));

  // ROM addresses plus valid/hit flags travelling alongside the ROM access
  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      valid_pipe <= '0;
      hit_pipe   <= '0;
      Bg_Addr_X  <= '0;
      Bg_Addr_Y  <= '0;
      Spr_Addr_X <= '0;
      Spr_Addr_Y <= '0;
    end else begin
      valid_pipe <= {valid_pipe[ROM_LATENCY-1:0], valid_c};
      hit_pipe   <= {hit_pipe[ROM_LATENCY-1:0], hit_c};
      Bg_Addr_X  <= Val_Col_In;
      Bg_Addr_Y  <= Val_Row_In;
      Spr_Addr_X <= SPR_AW'(rel_x_c);
      Spr_Addr_Y <= SPR_AW'(rel_y_c);
    end
  end

  // Colour select once ROM data lines up with its flags
  always_comb begin
    pix_c = '0;
    if (valid_pipe[ROM_LATENCY]) begin
      if (hit_pipe[ROM_LATENCY] && !(KEY_EN && (Spr_Data_In == TRANSPARENT_KEY)))
        pix_c = Spr_Data_In;
      else
        pix_c = Bg_Data_In;
    end
  end

  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else begin
      Red   <= pix_c[11:8];
      Green <= pix_c[7:4];
      Blue  <= pix_c[3:0];
    end
  end

  // Wrap or clamp a signed candidate coordinate into [0, maxv]
  function automatic logic [9:0] fit_axis(input logic signed [10:0] v,
                                          input logic [10:0] maxv,
                                          input logic clamp);
    logic [9:0] r;
    if (v < 11'sd0)
      r = clamp ? 10'd0 : maxv[9:0];
    else if (v > $signed(maxv))
      r = clamp ? maxv[9:0] : 10'd0;
    else
      r = v[9:0];
    return r;
  endfunction

  // Candidate position for this frame; opposing buttons cancel on their axis
  always_comb begin
    h_eff_c = Left ^ Right;
    v_eff_c = Up ^ Down;
    step_c  = (state == FAST) ? $signed(11'(FAST_STEP)) : $signed(11'(STEP));
    dx_c    = '0;
    dy_c    = '0;
    if (Right && !Left) dx_c = step_c;
    if (Left && !Right) dx_c = -step_c;
    if (Down && !Up)    dy_c = step_c;
    if (Up && !Down)    dy_c = -step_c;
    nx_c     = $signed(sx_w) + dx_c;
    ny_c     = $signed(sy_w) + dy_c;
    next_x_c = fit_axis(nx_c, X_MAX, Edge_Mode_In);
    next_y_c = fit_axis(ny_c, Y_MAX, Edge_Mode_In);
  end

  // Move FSM: position, hold counter and speed change only on the last visible pixel
  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      state      <= NORMAL;
      hold_cnt   <= '0;
      Sprite_X   <= 10'(START_X);
      Sprite_Y   <= 10'(START_Y);
      Frame_Tick <= 1'b0;
    end else begin
      Frame_Tick <= frame_end_c;
      if (frame_end_c) begin
        Sprite_X <= next_x_c;
        Sprite_Y <= next_y_c;
        if (h_eff_c || v_eff_c) begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt >= HOLD_LAST) state <= FAST;
        end else begin
          hold_cnt <= '0;
          state    <= NORMAL;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench for vga_sprite_compositor with behavioural ROMs (latency 1).
module tb_vga_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst_n, disp, up, down, left, right, edge_mode;
  logic [9:0]  col, row, bg_ax, bg_ay, sx, sy;
  logic [11:0] bg_d, spr_d;
  logic [5:0]  spr_ax, spr_ay;
  logic [3:0]  red, green, blue;
  logic        tick;

  int checks = 0;
  int failures = 0;

  int m_x, m_y, m_cnt;
  bit m_fast;

  typedef struct {logic [11:0] rgb; int x; int y;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  vga_sprite_compositor dut (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Disp_Ena_In(disp),
    .Val_Col_In(col), .Val_Row_In(row),
    .Up(up), .Down(down), .Left(left), .Right(right), .Edge_Mode_In(edge_mode),
    .Bg_Addr_X(bg_ax), .Bg_Addr_Y(bg_ay), .Bg_Data_In(bg_d),
    .Spr_Addr_X(spr_ax), .Spr_Addr_Y(spr_ay), .Spr_Data_In(spr_d),
    .Red(red), .Green(green), .Blue(blue),
    .Sprite_X(sx), .Sprite_Y(sy), .Frame_Tick(tick)
  );

  function automatic logic [11:0] bg_fn(input logic [9:0] x, input logic [9:0] y);
    return {x[5:0], y[5:0]} ^ 12'h5A3;
  endfunction

  // Sprite texel (0,1) carries the transparent key; all others have top nibble 10xx
  function automatic logic [11:0] spr_fn(input logic [5:0] ax, input logic [5:0] ay);
    if (ax == 6'd0 && ay == 6'd1) return 12'hF0F;
    return {2'b10, ay, ax[3:0]};
  endfunction

  always @(posedge clk) begin
    bg_d  <= bg_fn(bg_ax, bg_ay);
    spr_d <= spr_fn(spr_ax, spr_ay);
  end

  function automatic logic [11:0] exp_pixel(input logic d, input int x, input int y,
                                            input int px, input int py);
    logic [11:0] bgc, sc;
    if (!d || x >= 640 || y >= 480) return 12'h000;
    bgc = bg_fn(10'(x), 10'(y));
    if (x >= px && x < px + 32 && y >= py && y < py + 64) begin
      sc = spr_fn(6'(x - px), 6'(y - py));
`ifdef SPRITE_TRANSPARENCY_EN
      if (sc == 12'hF0F) return bgc;
`endif
      return sc;
    end
    return bgc;
  endfunction

  function automatic int fit(input int v, input int maxv, input bit clamp);
    if (v < 0) return clamp ? 0 : maxv;
    if (v > maxv) return clamp ? maxv : 0;
    return v;
  endfunction

  function automatic void model_frame(input bit u, input bit dn, input bit l,
                                      input bit rt, input bit clamp);
    int st, nx, ny;
    st = m_fast ? 4 : 1;
    nx = m_x;
    ny = m_y;
    if (l && !rt) nx -= st; else if (rt && !l) nx += st;
    if (u && !dn) ny -= st; else if (dn && !u) ny += st;
    if ((l ^ rt) || (u ^ dn)) begin
      if (m_cnt < 30) m_cnt++;
      if (m_cnt >= 30) m_fast = 1'b1;
    end else begin
      m_cnt  = 0;
      m_fast = 1'b0;
    end
    m_x = fit(nx, 608, clamp);
    m_y = fit(ny, 416, clamp);
  endfunction

  // One frame-end pixel with buttons, then one idle cycle; reports Frame_Tick after each edge
  task automatic do_frame(input bit u, input bit dn, input bit l, input bit rt,
                          input bit md, output logic t1, output logic t2);
    @(negedge clk);
    disp = 1'b1; col = 10'd639; row = 10'd479;
    up = u; down = dn; left = l; right = rt; edge_mode = md;
    @(posedge clk); #1;
    t1 = tick;
    @(negedge clk);
    disp = 1'b0; col = 10'd0; row = 10'd0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    @(posedge clk); #1;
    t2 = tick;
    model_frame(u, dn, l, rt, md);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; disp = 1'b0; col = '0; row = '0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; edge_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      failures++; $display("FAIL reset_rgb got=%h want=000", {red, green, blue});
    end
    checks++;
    if (sx !== 10'd304 || sy !== 10'd208) begin
      failures++; $display("FAIL reset_pos got=%0d,%0d want=304,208", sx, sy);
    end
    checks++;
    if (tick !== 1'b0) begin
      failures++; $display("FAIL reset_tick got=%b want=0", tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_x = 304; m_y = 208; m_cnt = 0; m_fast = 1'b0;
  endtask

  task automatic test_pixels;
    int px[11] = '{0, 304, 336, 335, 304, 303, 304, 304, 640, 10, 639};
    int py[11] = '{0, 208, 208, 271, 272, 208, 209, 208, 10, 480, 0};
    bit pd[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    int x, y;
    bit d;
    exp_t e;
    for (int i = 0; i < 34; i++) begin
      if (i < 11) begin
        x = px[i]; y = py[i]; d = pd[i];
      end else if (i < 31) begin
        x = int'($urandom_range(350, 280)); y = int'($urandom_range(290, 190)); d = 1'b1;
      end else begin
        x = 5; y = 5; d = 1'b0;
      end
      @(negedge clk);
      disp = d; col = 10'(x); row = 10'(y);
      exp_q.push_back('{exp_pixel(d, x, y, 304, 208), x, y});
      @(posedge clk); #1;
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if ({red, green, blue} !== e.rgb) begin
          failures++;
          $display("FAIL pixel(%0d,%0d) got=%h want=%h", e.x, e.y, {red, green, blue}, e.rgb);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_accel;
    logic t1, t2;
    int run = 0;
    for (int f = 0; f < 400 && m_x != 100; f++) begin
      if (run == 29) begin
        do_frame(0, 0, 0, 0, 0, t1, t2); run = 0;
      end else begin
        do_frame(0, 0, 1, 0, 0, t1, t2); run++;
      end
      checks++;
      if (sx !== 10'(m_x)) begin
        failures++; $display("FAIL walk_x got=%0d want=%0d", sx, m_x);
      end
    end
    checks++;
    if (sx !== 10'd100) begin
      failures++; $display("FAIL walk_reach got=%0d want=100", sx);
    end
    do_frame(0, 0, 0, 0, 0, t1, t2);
    for (int f = 1; f <= 31; f++) begin
      do_frame(0, 0, 0, 1, 0, t1, t2);
      if (f == 30) begin
        checks++;
        if (sx !== 10'd130) begin
          failures++; $display("FAIL accel_30 got=%0d want=130", sx);
        end
      end
    end
    checks++;
    if (sx !== 10'd134) begin
      failures++; $display("FAIL accel_31 got=%0d want=134", sx);
    end
    do_frame(0, 0, 0, 0, 0, t1, t2);
    checks++;
    if (sx !== 10'd134) begin
      failures++; $display("FAIL release_hold got=%0d want=134", sx);
    end
    do_frame(0, 0, 0, 1, 0, t1, t2);
    checks++;
    if (sx !== 10'd135) begin
      failures++; $display("FAIL release_step got=%0d want=135", sx);
    end
    checks++;
    if (t1 !== 1'b1 || t2 !== 1'b0) begin
      failures++; $display("FAIL tick_pulse got=%b%b want=10", t1, t2);
    end
  endtask

  task automatic test_edges;
    logic t1, t2;
    for (int f = 0; f < 200 && m_x != 0; f++) begin
      do_frame(0, 0, 1, 0, 1, t1, t2);
      checks++;
      if (sx !== 10'(m_x)) begin
        failures++; $display("FAIL clamp_walk got=%0d want=%0d", sx, m_x);
      end
    end
    do_frame(0, 0, 1, 0, 1, t1, t2);
    checks++;
    if (sx !== 10'd0) begin
      failures++; $display("FAIL clamp_low got=%0d want=0", sx);
    end
    do_frame(0, 0, 1, 0, 0, t1, t2);
    checks++;
    if (sx !== 10'd608) begin
      failures++; $display("FAIL wrap_low got=%0d want=608", sx);
    end
    checks++;
    if (t1 !== 1'b1 || t2 !== 1'b0) begin
      failures++; $display("FAIL wrap_tick got=%b%b want=10", t1, t2);
    end
    do_frame(0, 0, 0, 1, 0, t1, t2);
    checks++;
    if (sx !== 10'd0) begin
      failures++; $display("FAIL wrap_high got=%0d want=0", sx);
    end
    do_frame(0, 0, 1, 0, 0, t1, t2);
    do_frame(0, 0, 0, 1, 1, t1, t2);
    checks++;
    if (sx !== 10'd608) begin
      failures++; $display("FAIL clamp_high got=%0d want=608", sx);
    end
  endtask

  task automatic test_vertical;
    logic t1, t2;
    do_frame(1, 1, 0, 0, 0, t1, t2);
    checks++;
    if (sy !== 10'd208 || sx !== 10'd608) begin
      failures++; $display("FAIL up_down_cancel got=%0d,%0d want=608,208", sx, sy);
    end
    do_frame(0, 1, 0, 0, 0, t1, t2);
    checks++;
    if (sy !== 10'd209) begin
      failures++; $display("FAIL down_step got=%0d want=209", sy);
    end
    do_frame(1, 0, 0, 0, 0, t1, t2);
    checks++;
    if (sy !== 10'd208) begin
      failures++; $display("FAIL up_step got=%0d want=208", sy);
    end
    // Buttons away from the frame-end pixel must not move the sprite
    @(negedge clk);
    disp = 1'b1; col = 10'd100; row = 10'd100; left = 1'b1; down = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (sx !== 10'd608 || sy !== 10'd208 || tick !== 1'b0) begin
      failures++; $display("FAIL mid_frame_sample got=%0d,%0d,%b want=608,208,0", sx, sy, tick);
    end
    @(negedge clk);
    left = 1'b0; down = 1'b0; disp = 1'b0;
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    disp = 1'b1; col = 10'd0; row = 10'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({red, green, blue} !== 12'h000 || sx !== 10'd304 || sy !== 10'd208) begin
      failures++;
      $display("FAIL midreset_state got=%h,%0d,%0d want=000,304,208", {red, green, blue}, sx, sy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({red, green, blue} !== ((k == 3) ? bg_fn(10'd0, 10'd0) : 12'h000)) begin
        failures++;
        $display("FAIL midreset_flush cycle=%0d got=%h want=%h", k, {red, green, blue},
                 (k == 3) ? bg_fn(10'd0, 10'd0) : 12'h000);
      end
    end
    @(negedge clk);
    disp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_accel();
    test_edges();
    test_vertical();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
